// File: rtl/ib_rx_fifo.sv
// rtl/ib_rx_fifo.sv - receive byte/talk FIFO between the serial receiver and the instrument-bus logic
// Bytes and talk markers share one ordered queue; backpressure withholds rx_ack_n / rx_talk_ack.
module ib_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ack_n,
  input  logic                     rx_talk,
  output logic                     rx_talk_ack,
  input  logic                     flush,
  output logic [7:0]               out_data,
  output logic                     out_talk,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {ING_IDLE, ING_ACK} ing_state_t;

  ing_state_t    state_q, state_d;
  logic          rx_ack_n_q, rx_ack_n_d;
  logic          rx_talk_ack_q, rx_talk_ack_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [8:0]    mem_q [DEPTH];

  logic       full;
  logic       talk_wr;
  logic       data_wr;
  logic       wr_en;
  logic       rd_en;
  logic [8:0] wr_entry;

  assign full = (level_q == LW'(DEPTH));

  // Talk wins over data, and the cycle after a talk ack is dead so a still-high rx_talk is not re-queued.
  assign talk_wr  = rx_talk && !rx_talk_ack_q && !full && (state_q == ING_IDLE);
  assign data_wr  = rx_valid && !rx_talk && !rx_talk_ack_q && !full && (state_q == ING_IDLE);
  assign wr_en    = talk_wr || data_wr;
  assign rd_en    = (level_q != '0) && out_ready;
  assign wr_entry = talk_wr ? 9'h100 : {1'b0, rx_data};

  always_comb begin
    state_d       = state_q;
    rx_ack_n_d    = rx_ack_n_q;
    rx_talk_ack_d = talk_wr;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;

    case (state_q)
      ING_IDLE: begin
        if (data_wr) begin
          state_d    = ING_ACK;
          rx_ack_n_d = 1'b0;
        end
      end
      ING_ACK: begin
        if (!rx_valid) begin
          state_d    = ING_IDLE;
          rx_ack_n_d = 1'b1;
        end
      end
      default: begin
        state_d    = ING_IDLE;
        rx_ack_n_d = 1'b1;
      end
    endcase

    // Flush drops queue state only; the handshake sequencing above still completes.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ING_IDLE;
      rx_ack_n_q    <= 1'b1;
      rx_talk_ack_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      rx_ack_n_q    <= rx_ack_n_d;
      rx_talk_ack_q <= rx_talk_ack_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is masked when empty so stale contents never show after reset or flush.
  assign out_valid   = (level_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign out_talk    = out_valid && mem_q[rd_ptr_q][8];
  assign rx_ack_n    = rx_ack_n_q;
  assign rx_talk_ack = rx_talk_ack_q;
  assign level       = level_q;

endmodule

// File: tb/tb_ib_rx_fifo.sv
// tb/tb_ib_rx_fifo.sv - directed self-checking bench for ib_rx_fifo
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_ib_rx_fifo;
  logic       clk;
  logic       nrst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack_n;
  logic       rx_talk;
  logic       rx_talk_ack;
  logic       flush;
  logic [7:0] out_data;
  logic       out_talk;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;

  int compared;
  int mismatched;

  ib_rx_fifo #(.DEPTH(8)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack_n   (rx_ack_n),
    .rx_talk    (rx_talk),
    .rx_talk_ack(rx_talk_ack),
    .flush      (flush),
    .out_data   (out_data),
    .out_talk   (out_talk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: present byte, drop valid once acked, ack must rise one edge later.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    chk("send_ack_lo", rx_ack_n, 0);
    rx_valid = 1'b0;
    step();
    chk("send_ack_hi", rx_ack_n, 1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nrst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_talk = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_ack_n", rx_ack_n, 1);
    chk("rst_talk_ack", rx_talk_ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_talk", out_talk, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_level", level, 0);
    nrst = 1'b1;
    step();

    // Single byte
    rx_data = 8'h41; rx_valid = 1'b1;
    step();
    chk("sb_ack_lo", rx_ack_n, 0);
    chk("sb_valid", out_valid, 1);
    chk("sb_data", out_data, 8'h41);
    chk("sb_talk", out_talk, 0);
    chk("sb_level", level, 1);
    rx_valid = 1'b0;
    step();
    chk("sb_ack_still_lo_before", level, 1);
    chk("sb_ack_hi", rx_ack_n, 1);
    out_ready = 1'b1;
    step();
    chk("sb_drain_level", level, 0);
    chk("sb_drain_valid", out_valid, 0);
    chk("sb_drain_data", out_data, 8'h00);

    // Talk ordering with out_ready held high
    rx_data = 8'h10; rx_valid = 1'b1;
    step();
    chk("to_d0_data", out_data, 8'h10);
    chk("to_d0_talk", out_talk, 0);
    rx_valid = 1'b0;
    step();
    chk("to_d0_read", level, 0);
    rx_talk = 1'b1;
    step();
    chk("to_tk_ack", rx_talk_ack, 1);
    chk("to_tk_talk", out_talk, 1);
    chk("to_tk_data", out_data, 8'h00);
    rx_talk = 1'b0;
    step();
    chk("to_tk_ack_clr", rx_talk_ack, 0);
    chk("to_tk_read", level, 0);
    rx_data = 8'h20; rx_valid = 1'b1;
    step();
    chk("to_d1_data", out_data, 8'h20);
    chk("to_d1_talk", out_talk, 0);
    chk("to_d1_level", level, 1);
    chk("to_talk_ack_idle", rx_talk_ack, 0);
    rx_valid = 1'b0;
    step();
    chk("to_end_level", level, 0);
    out_ready = 1'b0;

    // Talk and data offered together: talk first, data two edges later
    rx_talk = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    step();
    chk("sim_talk_ack", rx_talk_ack, 1);
    chk("sim_ack_n_1", rx_ack_n, 1);
    chk("sim_level_1", level, 1);
    rx_talk = 1'b0;
    step();
    chk("sim_talk_ack_clr", rx_talk_ack, 0);
    chk("sim_ack_n_2", rx_ack_n, 1);
    chk("sim_level_2", level, 1);
    step();
    chk("sim_ack_n_lo", rx_ack_n, 0);
    chk("sim_level_3", level, 2);
    rx_valid = 1'b0;
    step();
    chk("sim_ack_n_hi", rx_ack_n, 1);
    chk("sim_head_talk", out_talk, 1);
    out_ready = 1'b1;
    step();
    chk("sim_2nd_talk", out_talk, 0);
    chk("sim_2nd_data", out_data, 8'h33);
    step();
    chk("sim_empty", level, 0);
    out_ready = 1'b0;

    // Full backpressure
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    chk("full_level", level, 8);
    rx_data = 8'h08; rx_valid = 1'b1;
    step(); step(); step();
    chk("full_no_ack", rx_ack_n, 1);
    chk("full_level_sat", level, 8);
    chk("full_head", out_data, 8'h00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_pop_level", level, 7);
    chk("full_pop_head", out_data, 8'h01);
    chk("full_pop_no_ack", rx_ack_n, 1);
    step();
    chk("full_late_ack", rx_ack_n, 0);
    chk("full_late_level", level, 8);
    rx_valid = 1'b0;
    step();
    chk("full_late_ack_hi", rx_ack_n, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("full_drain_data", out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("full_drain_level", level, 0);

    // Flush coincident with an ingest write
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
    chk("fl_pre_level", level, 3);
    rx_data = 8'hA3; rx_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ack_lo", rx_ack_n, 0);
    rx_valid = 1'b0;
    step();
    chk("fl_ack_hi", rx_ack_n, 1);
    chk("fl_level_after", level, 0);

    // Reset in the middle of a handshake
    rx_data = 8'h55; rx_valid = 1'b1;
    step();
    chk("rm_ack_lo", rx_ack_n, 0);
    chk("rm_level", level, 1);
    #2 nrst = 1'b0;
    #1;
    chk("rm_async_ack", rx_ack_n, 1);
    chk("rm_async_level", level, 0);
    chk("rm_async_valid", out_valid, 0);
    rx_valid = 1'b0;
    step();
    nrst = 1'b1;
    step();
    rx_data = 8'h66; rx_valid = 1'b1;
    step();
    chk("rm_resume_ack", rx_ack_n, 0);
    chk("rm_resume_data", out_data, 8'h66);
    chk("rm_resume_level", level, 1);
    rx_valid = 1'b0;
    step();
    chk("rm_resume_ack_hi", rx_ack_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ib_rx_fifo.md
# ib_rx_fifo

Receive-side buffer directly downstream of the serial byte receiver in the IB FPGA. Consumes received bytes through the receiver's valid / active-low-ack handshake and the out-of-band talk flag, which the receiver raises on byte 0xFE. Both are queued in arrival order in a small FIFO and presented to the instrument-bus logic on a valid/ready interface. Backpressure is applied by withholding the ack, which stalls the receiver and holds its RTS deasserted, so no byte is ever dropped.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte; stable while rx_valid high
- rx_valid  in  1  receiver has a byte
- rx_ack_n  out  1  active-low ack to receiver; registered
- rx_talk  in  1  talk request from receiver; held until acked
- rx_talk_ack  out  1  one-cycle registered ack of rx_talk
- flush  in  1  synchronous FIFO clear
- out_data  out  8  head entry byte (0x00 for talk entries)
- out_talk  out  1  head entry is a talk marker
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Entry format: 9 bits {talk, byte}. Data entry = {0, rx_data}. Talk entry = {1, 8'h00}.
- Storage: register array, write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- full = (level == DEPTH). empty = (level == 0).
- Talk path, priority over data:
  - Condition: rx_talk=1, rx_talk_ack=0, ~full, ingest FSM in ING_IDLE.
  - Action: write a talk entry; register rx_talk_ack<=1.
  - Next cycle: rx_talk_ack<=0 unconditionally, with no write, even though rx_talk is still high. This prevents a double enqueue.
- Ingest FSM:
  - ING_IDLE → ING_ACK when rx_valid=1 & ~full & rx_talk=0 & rx_talk_ack=0. On that transition: write data entry and set rx_ack_n<=0.
  - ING_ACK: hold rx_ack_n=0; no writes. When rx_valid=0: set rx_ack_n<=1 and go to ING_IDLE.
  - At most one write per received byte, regardless of how long rx_valid lingers after the ack.
- Read: when out_valid & out_ready, advance read pointer. out_data/out_talk are show-ahead from the head entry.
- Simultaneous read and write: allowed at any level below DEPTH, and level is unchanged. A write is never accepted at full, even if a read occurs in the same cycle.
- flush=1: pointers and level go to 0 at the next edge.
  - flush overrides a same-cycle read or write. A flushed write is still acked; the ingest FSM and talk ack sequence are unaffected.
- Full: rx_ack_n and rx_talk_ack are withheld until space exists. The receiver stays in its wait state.

## Timing
- Reset values: rx_ack_n=1, rx_talk_ack=0, out_valid=0, out_talk=0, out_data=0x00, level=0. Ingest FSM in ING_IDLE, pointers 0.
- Reset mid-handshake: rx_ack_n returns to 1 immediately (async). FIFO contents are discarded.
- Write latency: an entry accepted at edge E is visible on out_* with out_valid=1 after E. There is no combinational path from rx_* to out_*.
- level updates at the same edge as the write/read.
- rx_ack_n falls at the same edge as the write. It rises at the first edge after rx_valid is sampled low.
- rx_talk_ack is high for exactly one cycle per talk entry.
- out_ready does not combinationally affect any rx_* output.

## Test plan
- Single byte: rx_data=0x41, rx_valid pulse with a receiver model → one entry {0,0x41}.
  - out_valid rises the cycle after the write; level=1.
  - rx_ack_n low from the write edge until one cycle after rx_valid falls.
- Talk ordering: bytes 0x10, then talk, then 0x20, out_ready=1 throughout → outputs in order (0x10,talk=0), (0x00,talk=1), (0x20,talk=0).
  - rx_talk_ack is a single one-cycle pulse; exactly 3 entries.
- Simultaneous talk and rx_valid in the same cycle → the talk entry is written first, the data entry afterwards; rx_ack_n asserts only after rx_talk_ack has completed.
- Full backpressure: DEPTH=8, out_ready=0, send 9 bytes 0x00..0x08.
  - level saturates at 8; the 9th byte stays un-acked (rx_ack_n=1).
  - Raise out_ready for one cycle → 0x00 is read out, 0x08 is then acked and written, level=8.
- Flush with a concurrent write: level=3 and flush asserted in the same cycle as an ingest write → level=0, out_valid=0.
  - rx_ack_n still completes its low/high sequence.
- Reset mid-handshake: nrst low while in ING_ACK → rx_ack_n=1, level=0, out_valid=0 immediately. Normal reception resumes after reset release.
